scan_chain_responder: RTL

- Project-side end of the Tiny Tapeout scan chain: the cell that the scan controller shifts into and out of.
- Oversamples the scan signals (scan_clk, scan_data, scan_select, latch_enable) on the system clock.
- Shifts serial data through an internal register and latches WIDTH project inputs. Captures WIDTH project outputs for shift-out.
- Forwards the chain signals to the next cell and emits a one-cycle ready pulse after each input update.

---
 rtl/scan_chain_if.sv | 37 +++
 rtl/scan_chain_responder.sv | 106 ++++++++++
 2 files changed

// File: rtl/scan_chain_if.sv
`default_nettype none
// ============================================================================
// Module      : scan_chain_if
// Description : Scan-chain cell signal bundle (chain in/out plus project side)
// Revision    : 1.0 - initial release
// ============================================================================
interface scan_chain_if #(
  parameter int WIDTH = 8
);
  logic             scan_clk_in;
  logic             scan_data_in;
  logic             scan_select_in;
  logic             latch_enable_in;
  logic [WIDTH-1:0] module_data_out;
  logic             scan_clk_out;
  logic             scan_data_out;
  logic             scan_select_out;
  logic             latch_enable_out;
  logic [WIDTH-1:0] module_data_in;
  logic             ready;
  logic [7:0]       shift_count;

  modport slave (
    input  scan_clk_in, scan_data_in, scan_select_in, latch_enable_in,
    input  module_data_out,
    output scan_clk_out, scan_data_out, scan_select_out, latch_enable_out,
    output module_data_in, ready, shift_count
  );

  modport master (
    output scan_clk_in, scan_data_in, scan_select_in, latch_enable_in,
    output module_data_out,
    input  scan_clk_out, scan_data_out, scan_select_out, latch_enable_out,
    input  module_data_in, ready, shift_count
  );
endinterface
`default_nettype wire

// File: rtl/scan_chain_responder.sv
`default_nettype none
// ============================================================================
// Module      : scan_chain_responder
// Description : Project-side scan-chain cell: oversampled shift/capture/latch
// Revision    : 1.0 - initial release
// ============================================================================
module scan_chain_responder #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic   clk,
  input  wire logic   reset,
  scan_chain_if.slave bus
);

  localparam int NSIG = 4;
  localparam int SW   = SYNC_STAGES * NSIG;

  // Stage k of the synchroniser occupies bits [k*4 +: 4]; order is {latch, sel, data, clk}.
  logic [SW-1:0]        sync_q, sync_d;
  logic [SYNC_STAGES:0] warm_q, warm_d;
  logic                 hist_clk_q, hist_clk_d;
  logic                 hist_latch_q, hist_latch_d;
  logic [WIDTH-1:0]     sreg_q, sreg_d;
  logic [WIDTH-1:0]     data_in_q, data_in_d;
  logic                 sdo_q, sdo_d;
  logic                 ready_q, ready_d;
  logic [7:0]           count_q, count_d;

  logic [NSIG-1:0]      sync_now;
  logic                 s_clk, s_data, s_sel, s_latch;
  logic                 primed;
  logic                 clk_rise, clk_fall, latch_rise, shift_en;

  assign sync_now = sync_q[SW-1 -: NSIG];
  assign s_clk    = sync_now[0];
  assign s_data   = sync_now[1];
  assign s_sel    = sync_now[2];
  assign s_latch  = sync_now[3];

  // Edges are masked until the history flops hold a re-acquired level, so a
  // line already high when reset releases is not mistaken for a rising edge.
  assign primed     = warm_q[SYNC_STAGES];
  assign clk_rise   = primed &  s_clk   & ~hist_clk_q;
  assign clk_fall   = primed & ~s_clk   &  hist_clk_q;
  assign latch_rise = primed &  s_latch & ~hist_latch_q;
  assign shift_en   = clk_rise & ~s_sel;

  always_comb begin
    sync_d       = {sync_q[SW-NSIG-1:0], bus.latch_enable_in, bus.scan_select_in,
                    bus.scan_data_in, bus.scan_clk_in};
    warm_d       = {warm_q[SYNC_STAGES-1:0], 1'b1};
    hist_clk_d   = s_clk;
    hist_latch_d = s_latch;

    sreg_d = sreg_q;
    if (clk_rise) begin
      if (s_sel) sreg_d = bus.module_data_out;
      else       sreg_d = {sreg_q[WIDTH-2:0], s_data};
    end

    // Falling-edge update gives the next cell half a scan period of hold.
    sdo_d = clk_fall ? sreg_q[WIDTH-1] : sdo_q;

    data_in_d = latch_rise ? sreg_q : data_in_q;
    ready_d   = latch_rise;

    if (latch_rise)                          count_d = {7'd0, shift_en};
    else if (shift_en && count_q != 8'hFF)   count_d = count_q + 8'd1;
    else                                     count_d = count_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q       <= '0;
      warm_q       <= '0;
      hist_clk_q   <= 1'b0;
      hist_latch_q <= 1'b0;
      sreg_q       <= '0;
      data_in_q    <= '0;
      sdo_q        <= 1'b0;
      ready_q      <= 1'b0;
      count_q      <= 8'd0;
    end else begin
      sync_q       <= sync_d;
      warm_q       <= warm_d;
      hist_clk_q   <= hist_clk_d;
      hist_latch_q <= hist_latch_d;
      sreg_q       <= sreg_d;
      data_in_q    <= data_in_d;
      sdo_q        <= sdo_d;
      ready_q      <= ready_d;
      count_q      <= count_d;
    end
  end

  assign bus.scan_clk_out     = s_clk;
  assign bus.scan_select_out  = s_sel;
  assign bus.latch_enable_out = s_latch;
  assign bus.scan_data_out    = sdo_q;
  assign bus.module_data_in   = data_in_q;
  assign bus.ready            = ready_q;
  assign bus.shift_count      = count_q;

endmodule
`default_nettype wire
